// File: rtl/turn_controller_pkg.sv
// Shared Connect-4 definitions: board geometry, state-bus codes, winner codes and FSM encodings.
package turn_controller_pkg;

  localparam int ROWS = 6;
  localparam int COLS = 7;

  localparam logic [1:0] ST_HOLD  = 2'b00;
  localparam logic [1:0] ST_P1    = 2'b01;
  localparam logic [1:0] ST_P2    = 2'b10;
  localparam logic [1:0] ST_CLEAR = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  typedef enum logic [2:0] {
    FSM_CLEAR  = 3'd0,
    FSM_WAIT   = 3'd1,
    FSM_COMMIT = 3'd2,
    FSM_CHECK  = 3'd3,
    FSM_DONE   = 3'd4
  } fsm_t;

endpackage

// File: rtl/turn_controller_timer.sv
// Per-turn timer: counts while enabled, restarts on clear or on expiry.
// Only present in builds with TURN_TIMEOUT_EN defined.
`ifdef TURN_TIMEOUT_EN
module turn_controller_timer #(
  parameter int CYCLES = 67108864,
  localparam int W     = $clog2(CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  logic [W-1:0] cnt_r;

  assign expire = enable && (cnt_r == W'(CYCLES - 1));

  // turn cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clear || expire) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
endmodule
`endif

// File: rtl/turn_controller.sv
// Connect-4 turn sequencer: validates drops, drives the column state bus, alternates players, ends games.
// Optional per-turn forfeit timer is enabled with the TURN_TIMEOUT_EN macro.
module turn_controller
  import turn_controller_pkg::*;
#(
`ifdef TURN_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 67108864,
`endif
  parameter int MAX_MOVES    = ROWS * COLS,
  parameter int CHECK_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            drop_req,
  input  logic [COLS-1:0] in_column,
  input  logic            invalid_column,
  input  logic            win_detected,
  output logic [1:0]      state,
  output logic            current_player,
  output logic [5:0]      move_count,
  output logic            move_rejected,
  output logic            game_over,
  output logic [1:0]      winner
);
  fsm_t       fsm_r, fsm_next_s;
  logic [3:0] chk_cnt_r, chk_next_s;
  logic       player_next_s, reject_next_s;
  logic [5:0] count_next_s;
  logic [1:0] winner_next_s, state_next_s;
  logic       col_ok_s, expire_s;

  assign col_ok_s = (in_column != {COLS{1'b0}}) &&
                    ((in_column & (in_column - COLS'(1))) == {COLS{1'b0}});

`ifdef TURN_TIMEOUT_EN
  turn_controller_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (fsm_r != FSM_WAIT),
    .enable (fsm_r == FSM_WAIT),
    .expire (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // next-state and next-output decision
  always_comb begin
    fsm_next_s    = fsm_r;
    player_next_s = current_player;
    count_next_s  = move_count;
    winner_next_s = winner;
    reject_next_s = 1'b0;
    chk_next_s    = 4'd0;
    case (fsm_r)
      FSM_CLEAR: fsm_next_s = FSM_WAIT;
      FSM_WAIT: begin
        if (drop_req && col_ok_s && !invalid_column) begin
          fsm_next_s = FSM_COMMIT;
          if (move_count < 6'(MAX_MOVES)) begin
            count_next_s = move_count + 6'd1;
          end else begin
            count_next_s = move_count;
          end
        end else if (drop_req) begin
          reject_next_s = 1'b1;
        end else if (expire_s) begin
          // forfeit: the turn passes without a move
          player_next_s = ~current_player;
          reject_next_s = 1'b1;
        end else begin
          fsm_next_s = FSM_WAIT;
        end
      end
      FSM_COMMIT: fsm_next_s = FSM_CHECK;
      FSM_CHECK: begin
        if (chk_cnt_r == 4'(CHECK_CYCLES - 1)) begin
          if (win_detected) begin
            fsm_next_s    = FSM_DONE;
            winner_next_s = current_player ? WIN_P2 : WIN_P1;
          end else if (move_count >= 6'(MAX_MOVES)) begin
            fsm_next_s    = FSM_DONE;
            winner_next_s = WIN_NONE;
          end else begin
            fsm_next_s    = FSM_WAIT;
            player_next_s = ~current_player;
          end
        end else begin
          chk_next_s = chk_cnt_r + 4'd1;
        end
      end
      FSM_DONE: begin
        if (drop_req) begin
          fsm_next_s    = FSM_CLEAR;
          player_next_s = 1'b0;
          count_next_s  = 6'd0;
          winner_next_s = WIN_NONE;
        end else begin
          fsm_next_s = FSM_DONE;
        end
      end
      default: fsm_next_s = FSM_CLEAR;
    endcase
  end

  // state-bus code for the upcoming cycle
  always_comb begin
    state_next_s = ST_HOLD;
    case (fsm_next_s)
      FSM_CLEAR:  state_next_s = ST_CLEAR;
      FSM_COMMIT: state_next_s = current_player ? ST_P2 : ST_P1;
      default:    state_next_s = ST_HOLD;
    endcase
  end

  // FSM and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_r          <= FSM_CLEAR;
      chk_cnt_r      <= 4'd0;
      state          <= ST_CLEAR;
      current_player <= 1'b0;
      move_count     <= 6'd0;
      move_rejected  <= 1'b0;
      game_over      <= 1'b0;
      winner         <= WIN_NONE;
    end else begin
      fsm_r          <= fsm_next_s;
      chk_cnt_r      <= chk_next_s;
      state          <= state_next_s;
      current_player <= player_next_s;
      move_count     <= count_next_s;
      move_rejected  <= reject_next_s;
      game_over      <= (fsm_next_s == FSM_DONE);
      winner         <= winner_next_s;
    end
  end
endmodule
